// File: rtl/framebuffer_dp_pattern_ram.sv
// Simple-dual-port framebuffer with a pattern fill engine that owns the write port after reset and on request.
// Optional FB_OUT_REG_EN adds a second read output register (2-cycle read latency).
module framebuffer_dp_pattern_ram #(
   parameter int              H_RES    = 640,
   parameter int              V_RES    = 480,
   parameter int              PIX_W    = 4,
   parameter int              ADDR_W   = 19,
   parameter logic [PIX_W-1:0] FILL_A  = 4'hF,
   parameter logic [PIX_W-1:0] FILL_B  = 4'h0,
   parameter logic [1:0]      RST_MODE = 2'd1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_req,
   input  logic [1:0]        clear_mode,
   output logic              busy,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   output logic              wr_err,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_data,
   output logic              rd_valid
);

   localparam int DEPTH = H_RES * V_RES;
   localparam int MA    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW    = (V_RES > 1) ? $clog2(V_RES) : 1;

   // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
   localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
   localparam logic [XW-1:0]   X_LAST  = XW'(H_RES - 1);
   localparam logic [YW-1:0]   Y_LAST  = YW'(V_RES - 1);

   typedef enum logic {S_FILL, S_IDLE} state_t;

   state_t            state;
   logic [XW-1:0]     fill_x;
   logic [YW-1:0]     fill_y;
   logic [ADDR_W-1:0] fill_addr;
   logic [1:0]        fill_mode;

   logic [PIX_W-1:0]  mem [0:DEPTH-1];
   logic              mem_we;
   logic [MA-1:0]     mem_waddr;
   logic [PIX_W-1:0]  mem_wdata;

   logic              wr_acc;
   logic              wr_in_rng;
   logic              rd_in_rng;

   logic [PIX_W-1:0]  rd_data_p1;
   logic              vld_p1;

   function automatic logic [PIX_W-1:0] pattern_pix(input logic [1:0] mode,
                                                    input logic x0, input logic y0);
      case (mode)
         2'd0:    return FILL_A;
         2'd1:    return x0 ? FILL_B : FILL_A;
         2'd2:    return y0 ? FILL_B : FILL_A;
         default: return (x0 ^ y0) ? FILL_B : FILL_A;
      endcase
   endfunction

   assign wr_ready  = ~busy;
   assign wr_acc    = wr_valid & ~busy;
   assign wr_in_rng = {1'b0, wr_addr} < DEPTH_A;
   assign rd_in_rng = {1'b0, rd_addr} < DEPTH_A;

   // The fill engine has priority; host writes only land while idle and in range.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr[MA-1:0];
      mem_wdata = wr_data;
      if (state == S_FILL) begin
         mem_we    = 1'b1;
         mem_waddr = fill_addr[MA-1:0];
         mem_wdata = pattern_pix(fill_mode, fill_x[0], fill_y[0]);
      end else if (wr_acc && wr_in_rng) begin
         mem_we    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FILL;
         busy      <= 1'b1;
         fill_x    <= '0;
         fill_y    <= '0;
         fill_addr <= '0;
         fill_mode <= RST_MODE;
         wr_err    <= 1'b0;
      end else begin
         wr_err <= wr_acc & ~wr_in_rng;
         case (state)
            S_FILL: begin
               fill_addr <= fill_addr + ADDR_W'(1);
               if (fill_x == X_LAST) begin
                  fill_x <= '0;
                  if (fill_y == Y_LAST) begin
                     fill_y    <= '0;
                     fill_addr <= '0;
                     state     <= S_IDLE;
                     busy      <= 1'b0;
                  end else begin
                     fill_y <= fill_y + YW'(1);
                  end
               end else begin
                  fill_x <= fill_x + XW'(1);
               end
            end
            S_IDLE: begin
               if (clear_req) begin
                  state     <= S_FILL;
                  busy      <= 1'b1;
                  fill_mode <= clear_mode;
                  fill_x    <= '0;
                  fill_y    <= '0;
                  fill_addr <= '0;
               end
            end
            default: begin
               state <= S_FILL;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // Stage p1: registered read, read-first against the same-edge write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_p1 <= '0;
         vld_p1     <= 1'b0;
      end else begin
         vld_p1 <= rd_en;
         if (rd_en) rd_data_p1 <= rd_in_rng ? mem[rd_addr[MA-1:0]] : '0;
      end
   end

`ifdef FB_OUT_REG_EN
   logic [PIX_W-1:0] rd_data_p2;
   logic             vld_p2;

   // Stage p2: output register for BRAM timing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_p2 <= '0;
         vld_p2     <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) rd_data_p2 <= rd_data_p1;
      end
   end

   assign rd_data  = rd_data_p2;
   assign rd_valid = vld_p2;
`else
   assign rd_data  = rd_data_p1;
   assign rd_valid = vld_p1;
`endif

endmodule

// File: tb/tb_framebuffer_dp_pattern_ram.sv
// Self-checking bench for framebuffer_dp_pattern_ram on an 8x4 array with a pattern-based reference memory.
module tb_framebuffer_dp_pattern_ram;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int N  = H * V;
   localparam int PW = 4;
   localparam int AW = 6;
   localparam int RM = 1;
   localparam logic [PW-1:0] FA = 4'hF;
   localparam logic [PW-1:0] FB = 4'h0;
`ifdef FB_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk;
   logic          rst_n;
   logic          clear_req;
   logic [1:0]    clear_mode;
   logic          busy;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [PW-1:0] wr_data;
   logic          wr_err;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [PW-1:0] rd_data;
   logic          rd_valid;

   int checks = 0;
   int errors = 0;

   logic [PW-1:0] model [0:N-1];
   logic [PW-1:0] got   [0:N-1];
   logic          gotv  [0:N-1];

   framebuffer_dp_pattern_ram #(
      .H_RES(H), .V_RES(V), .PIX_W(PW), .ADDR_W(AW),
      .FILL_A(FA), .FILL_B(FB), .RST_MODE(2'(RM))
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_mode(clear_mode),
      .busy(busy), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_err(wr_err), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [PW-1:0] pat(input int mode, input int a);
      int x;
      int y;
      x = a % H;
      y = a / H;
      case (mode)
         0:       return FA;
         1:       return (x % 2 == 0) ? FA : FB;
         2:       return (y % 2 == 0) ? FA : FB;
         default: return ((x + y) % 2 == 0) ? FA : FB;
      endcase
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic model_fill(input int mode);
      for (int a = 0; a < N; a++) model[a] = pat(mode, a);
   endtask

   task automatic read_one(input int a, output logic [PW-1:0] d, output logic v);
      rd_addr = AW'(a);
      rd_en   = 1'b1;
      step;
      rd_en   = 1'b0;
      for (int i = 1; i < LAT; i++) step;
      d = rd_data;
      v = rd_valid;
   endtask

   task automatic read_mem;
      for (int a = 0; a < N; a++) read_one(a, got[a], gotv[a]);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         step;
      end
   endtask

   task automatic start_fill(input int mode);
      clear_mode = 2'(mode);
      clear_req  = 1'b1;
      step;
      clear_req  = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      logic [PW-1:0] d;
      logic v;
      rst_n = 1'b0;
      rd_en = 1'b1;
      rd_addr = '0;
      step;
      step;
      rd_en = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
      checks++; if (rd_data !== 4'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      rst_n = 1'b1;
      count_busy(n);
      checks++; if (n != N) begin errors++; $display("FAIL reset_fill_len: got %0d expected %0d", n, N); end
      model_fill(RM);
      read_one(0, d, v);
      checks++; if (d !== 4'hF || v !== 1'b1) begin errors++; $display("FAIL reset_rd0: got %h/%b expected f/1", d, v); end
      read_one(1, d, v);
      checks++; if (d !== 4'h0 || v !== 1'b1) begin errors++; $display("FAIL reset_rd1: got %h/%b expected 0/1", d, v); end
      read_one(2, d, v);
      checks++; if (d !== 4'hF || v !== 1'b1) begin errors++; $display("FAIL reset_rd2: got %h/%b expected f/1", d, v); end
      read_mem;
      for (int a = 0; a < N; a++) begin
         checks++;
         if (got[a] !== model[a] || gotv[a] !== 1'b1)
            begin errors++; $display("FAIL reset_mem[%0d]: got %h/%b expected %h/1", a, got[a], gotv[a], model[a]); end
      end
   endtask

   task automatic test_checker_fill;
      int n;
      logic [PW-1:0] d;
      logic v;
      start_fill(3);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_rise: got %b expected 1", busy); end
      count_busy(n);
      checks++; if (n != N) begin errors++; $display("FAIL clear_fill_len: got %0d expected %0d", n, N); end
      model_fill(3);
      read_one(0, d, v);
      checks++; if (d !== 4'hF) begin errors++; $display("FAIL checker_rd0: got %h expected f", d); end
      read_one(1, d, v);
      checks++; if (d !== 4'h0) begin errors++; $display("FAIL checker_rd1: got %h expected 0", d); end
      read_one(8, d, v);
      checks++; if (d !== 4'h0) begin errors++; $display("FAIL checker_rd8: got %h expected 0", d); end
      read_one(9, d, v);
      checks++; if (d !== 4'hF) begin errors++; $display("FAIL checker_rd9: got %h expected f", d); end
   endtask

   task automatic test_random_fills;
      int n;
      int mode;
      for (int k = 0; k < 3; k++) begin
         mode = (k == 0) ? 2 : int'($urandom_range(0, 3));
         start_fill(mode);
         count_busy(n);
         checks++; if (n != N) begin errors++; $display("FAIL fill_len_mode%0d: got %0d expected %0d", mode, n, N); end
         model_fill(mode);
         read_mem;
         for (int a = 0; a < N; a++) begin
            checks++;
            if (got[a] !== model[a])
               begin errors++; $display("FAIL fill_mode%0d[%0d]: got %h expected %h", mode, a, got[a], model[a]); end
         end
      end
   endtask

   task automatic test_host_write;
      logic [PW-1:0] d;
      logic v;
      wr_addr  = AW'(5);
      wr_data  = 4'hA;
      wr_valid = 1'b1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_idle: got %b expected 1", wr_ready); end
      step;
      wr_valid = 1'b0;
      model[5] = 4'hA;
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_inrange: got %b expected 0", wr_err); end
      read_one(5, d, v);
      checks++; if (d !== 4'hA || v !== 1'b1) begin errors++; $display("FAIL wr_rd5: got %h/%b expected a/1", d, v); end
      wr_addr  = AW'(40);
      wr_data  = 4'h3;
      wr_valid = 1'b1;
      step;
      wr_valid = 1'b0;
      checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_pulse: got %b expected 1", wr_err); end
      step;
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_width: got %b expected 0", wr_err); end
      read_one(40, d, v);
      checks++; if (d !== 4'h0 || v !== 1'b1) begin errors++; $display("FAIL rd_oob: got %h/%b expected 0/1", d, v); end
      step;
      checks++; if (rd_valid !== 1'b0 || rd_data !== 4'h0)
         begin errors++; $display("FAIL rd_hold: got %h/%b expected 0/0", rd_data, rd_valid); end
      read_mem;
      for (int a = 0; a < N; a++) begin
         checks++;
         if (got[a] !== model[a])
            begin errors++; $display("FAIL oob_unchanged[%0d]: got %h expected %h", a, got[a], model[a]); end
      end
   endtask

   task automatic test_random_traffic;
      logic [PW-1:0] d0;
      logic v0;
      logic [PW-1:0] prev;
      logic qv[$];
      logic [PW-1:0] qd[$];
      int wa;
      int ra;
      logic wv;
      logic rv;
      logic [PW-1:0] wd;
      logic ev;
      logic [PW-1:0] ed;
      logic eerr;
      read_one(0, d0, v0);
      prev = d0;
      if (LAT == 2) begin qv.push_back(1'b0); qd.push_back(prev); end
      for (int c = 0; c < 200; c++) begin
         wv = 1'($urandom_range(0, 1));
         wa = int'($urandom_range(0, 47));
         wd = 4'($urandom);
         rv = 1'($urandom_range(0, 1));
         ra = (c % 4 == 0) ? wa : int'($urandom_range(0, 47));
         wr_valid = wv;
         wr_addr  = AW'(wa);
         wr_data  = wd;
         rd_en    = rv;
         rd_addr  = AW'(ra);
         if (rv) prev = (ra < N) ? model[ra] : 4'h0;
         qv.push_back(rv);
         qd.push_back(prev);
         eerr = wv && (wa >= N);
         if (wv && wa < N) model[wa] = wd;
         step;
         ev = qv.pop_front();
         ed = qd.pop_front();
         checks++; if (rd_valid !== ev) begin errors++; $display("FAIL rand_rd_valid c%0d: got %b expected %b", c, rd_valid, ev); end
         checks++; if (rd_data !== ed) begin errors++; $display("FAIL rand_rd_data c%0d: got %h expected %h", c, rd_data, ed); end
         checks++; if (wr_err !== eerr) begin errors++; $display("FAIL rand_wr_err c%0d: got %b expected %b", c, wr_err, eerr); end
      end
      wr_valid = 1'b0;
      rd_en    = 1'b0;
      step;
      step;
   endtask

   task automatic test_busy_hold;
      int n;
      int bad_ready;
      logic [PW-1:0] d;
      start_fill(2);
      n = 0;
      bad_ready = 0;
      while (busy === 1'b1 && n < 100) begin
         if (wr_ready !== 1'b0) bad_ready++;
         n++;
         if (n == 5) begin wr_valid = 1'b1; wr_addr = '0; wr_data = 4'h9; end
         if (n == 10) begin clear_req = 1'b1; clear_mode = 2'd0; end
         if (n == 11) clear_req = 1'b0;
         step;
      end
      checks++; if (bad_ready != 0) begin errors++; $display("FAIL hold_ready_busy: got %0d high cycles expected 0", bad_ready); end
      checks++; if (n != N) begin errors++; $display("FAIL hold_fill_len: got %0d expected %0d", n, N); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_idle: got %b expected 1", wr_ready); end
      rd_en   = 1'b1;
      rd_addr = '0;
      step;
      wr_valid = 1'b0;
      rd_en    = 1'b0;
      for (int i = 1; i < LAT; i++) step;
      d = rd_data;
      checks++; if (d !== pat(2, 0)) begin errors++; $display("FAIL hold_no_early_write: got %h expected %h", d, pat(2, 0)); end
      model_fill(2);
      model[0] = 4'h9;
      read_mem;
      for (int a = 0; a < N; a++) begin
         checks++;
         if (got[a] !== model[a])
            begin errors++; $display("FAIL hold_mem[%0d]: got %h expected %h", a, got[a], model[a]); end
      end
   endtask

   task automatic test_same_addr;
      logic [PW-1:0] d;
      logic v;
      wr_valid = 1'b1; wr_addr = AW'(3); wr_data = 4'hF;
      step;
      wr_valid = 1'b1; wr_addr = AW'(3); wr_data = 4'h7;
      rd_en = 1'b1; rd_addr = AW'(3);
      step;
      wr_valid = 1'b0;
      rd_en = 1'b0;
      checks++; if (rd_valid !== (LAT == 1)) begin errors++; $display("FAIL same_lat1: got %b expected %b", rd_valid, (LAT == 1)); end
      for (int i = 1; i < LAT; i++) step;
      checks++; if (rd_data !== 4'hF || rd_valid !== 1'b1)
         begin errors++; $display("FAIL same_read_first: got %h/%b expected f/1", rd_data, rd_valid); end
      step;
      checks++; if (rd_data !== 4'hF || rd_valid !== 1'b0)
         begin errors++; $display("FAIL same_hold: got %h/%b expected f/0", rd_data, rd_valid); end
      model[3] = 4'h7;
      read_one(3, d, v);
      checks++; if (d !== 4'h7) begin errors++; $display("FAIL same_new: got %h expected 7", d); end
   endtask

   task automatic test_reset_midfill;
      int n;
      start_fill(0);
      rd_addr = AW'(1);
      rd_en   = 1'b1;
      repeat (17) step;
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", rd_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid: got %b expected 0", rd_valid); end
      rd_en = 1'b0;
      step;
      step;
      rst_n = 1'b1;
      count_busy(n);
      checks++; if (n != N) begin errors++; $display("FAIL mid_refill_len: got %0d expected %0d", n, N); end
      model_fill(RM);
      read_mem;
      for (int a = 0; a < N; a++) begin
         checks++;
         if (got[a] !== model[a])
            begin errors++; $display("FAIL mid_mem[%0d]: got %h expected %h", a, got[a], model[a]); end
      end
   endtask

   initial begin
      rst_n      = 1'b1;
      clear_req  = 1'b0;
      clear_mode = 2'd0;
      wr_valid   = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      rd_en      = 1'b0;
      rd_addr    = '0;
      step;
      test_reset;
      test_checker_fill;
      test_random_fills;
      test_host_write;
      test_random_traffic;
      test_busy_hold;
      test_same_addr;
      test_reset_midfill;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
